// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the uart_rx receiver
// Contents: FSM state enum, data_bits encodings, oversample tick positions,
// per-frame capture struct and the last-data-bit helper.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state and parity fields).
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

    localparam logic [1:0] DATA_BITS_5 = 2'b00;
    localparam logic [1:0] DATA_BITS_6 = 2'b01;
    localparam logic [1:0] DATA_BITS_7 = 2'b10;
    localparam logic [1:0] DATA_BITS_8 = 2'b11;

    localparam logic [3:0] OVERSAMPLE_MID  = 4'd7;
    localparam logic [3:0] OVERSAMPLE_LAST = 4'd15;

    // Data plus the frame format latched at the start bit.
    typedef struct packed {
        logic [7:0] data;
        logic [1:0] data_bits;
        logic       stop_bits;
`ifdef UART_RX_PARITY_EN
        logic       parity_en;
        logic       parity_odd;
`endif
    } uart_rx_frame_t;

    // Index of the final data bit: 5 bits -> 4 ... 8 bits -> 7.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
        return {1'b0, data_bits} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// rtl/uart_rx_baud_gen.sv - oversample tick generator for uart_rx
// Ports: clk, reset (sync, active-high), clear (holds counter at 0),
// div (clocks per tick, 0 treated as 1), tick (one-cycle pulse on wrap).
module uart_rx_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    assign last = (div == '0) ? '0 : div - ONE;
    assign tick = !clear && (cnt == last);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with one-entry holding register
// Ports: clk, reset (sync, active-high), rx (async serial in), baud_div,
// data_bits, stop_bits, [parity_en, parity_odd], rx_data, rx_valid, rx_read,
// rx_done, framing_error, parity_error, overrun_error, rts_n.
// Optional feature macro: UART_RX_PARITY_EN (parity ports, PARITY state, parity_error).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic             stop_bits,
`ifdef UART_RX_PARITY_EN
    input  logic             parity_en,
    input  logic             parity_odd,
`endif
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_read,
    output logic             rx_done,
    output logic             framing_error,
    output logic             parity_error,
    output logic             overrun_error,
    output logic             rts_n
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_MID  = OVERSAMPLE_MID[TICK_W-1:0];
    localparam logic [TICK_W-1:0] TICK_LAST = OVERSAMPLE_LAST[TICK_W-1:0];
    localparam logic [TICK_W-1:0] TICK_ONE  = {{(TICK_W-1){1'b0}}, 1'b1};

    rx_state_t        state_q, state_d;
    logic             rx_meta, rx_sync, rx_prev;
    logic             start_edge;
    logic             tick;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]       bit_cnt;
    logic             stop_cnt;
    logic             fe_q;
    logic [DIV_W-1:0] div_q;
    uart_rx_frame_t   frame_q;
    logic             sample_mid, sample_last;
    logic             done_set;
`ifdef UART_RX_PARITY_EN
    logic             pe_q;
`endif

    assign start_edge  = rx_prev && !rx_sync;
    assign sample_mid  = tick && (tick_cnt == TICK_MID);
    assign sample_last = tick && (tick_cnt == TICK_LAST);

    // Divisor is latched with the frame format, so a baud_div change mid-frame
    // cannot stretch or shrink the current bit periods.
    uart_rx_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == IDLE),
        .div   (div_q),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) state_d = START;
            end
            START: begin
                // A line that is high again at mid-start was a glitch.
                if (sample_mid) state_d = rx_sync ? IDLE : DATA;
            end
            DATA: begin
                if (sample_last && (bit_cnt == last_bit_idx(frame_q.data_bits))) begin
`ifdef UART_RX_PARITY_EN
                    state_d = frame_q.parity_en ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_last) state_d = STOP;
            end
`endif
            STOP: begin
                // Leave at the mid-stop sample so a following start edge is not missed.
                if (sample_last && (!frame_q.stop_bits || stop_cnt)) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            fe_q     <= 1'b0;
            div_q    <= '0;
            frame_q  <= '0;
`ifdef UART_RX_PARITY_EN
            pe_q     <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    if (start_edge) begin
                        div_q             <= baud_div;
                        frame_q.data      <= '0;
                        frame_q.data_bits <= data_bits;
                        frame_q.stop_bits <= stop_bits;
`ifdef UART_RX_PARITY_EN
                        frame_q.parity_en  <= parity_en;
                        frame_q.parity_odd <= parity_odd;
                        pe_q               <= 1'b0;
`endif
                        fe_q              <= 1'b0;
                    end
                end
                START: begin
                    if (tick) tick_cnt <= sample_mid ? '0 : tick_cnt + TICK_ONE;
                end
                default: begin
                    if (tick) tick_cnt <= tick_cnt + TICK_ONE;
                    if (sample_last) begin
                        if (state_q == DATA) begin
                            frame_q.data[bit_cnt] <= rx_sync;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
`ifdef UART_RX_PARITY_EN
                        if (state_q == PARITY) begin
                            pe_q <= ((^frame_q.data) ^ rx_sync) != frame_q.parity_odd;
                        end
`endif
                        if (state_q == STOP) begin
                            stop_cnt <= 1'b1;
                            if (!rx_sync) fe_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Holding register and status flags. Error flags reflect the most
    // recently completed frame; overrun persists until the consumer reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_done       <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
            rts_n         <= 1'b0;
        end else begin
            rx_done <= done_set;
            rts_n   <= rx_valid;
            if (done_set) begin
                framing_error <= fe_q || !rx_sync;
                if (rx_valid && !rx_read) begin
                    overrun_error <= 1'b1;
                end else begin
                    rx_data  <= frame_q.data;
                    rx_valid <= 1'b1;
                    if (rx_read) overrun_error <= 1'b0;
                end
            end else if (rx_read) begin
                rx_valid      <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_error <= 1'b0;
        end else if (done_set) begin
            parity_error <= pe_q;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [15:0] baud_div;
    logic [1:0]  data_bits;
    logic        stop_bits;
    logic        parity_en;
    logic        parity_odd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_read;
    logic        rx_done;
    logic        framing_error;
    logic        parity_error;
    logic        overrun_error;
    logic        rts_n;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int d0;
    logic saw_data = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.DIV_W(16), .OVERSAMPLE(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .baud_div      (baud_div),
        .data_bits     (data_bits),
        .stop_bits     (stop_bits),
`ifdef UART_RX_PARITY_EN
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
`endif
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_read       (rx_read),
        .rx_done       (rx_done),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .overrun_error (overrun_error),
        .rts_n         (rts_n)
    );

    always @(negedge clk) begin
        if (rx_done) done_cnt++;
        if (dut.state_q == DATA) saw_data = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input int bit_clks,
                              input logic par_en, input logic par_bit,
                              input int nstop, input logic stop_val);
        hold(1'b0, bit_clks);
        for (int i = 0; i < nbits; i++) hold(data[i], bit_clks);
        if (par_en) hold(par_bit, bit_clks);
        for (int i = 0; i < nstop; i++) hold(stop_val, bit_clks);
        rx = 1'b1;
    endtask

    task automatic read_pulse();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; baud_div = 16'd1; data_bits = DATA_BITS_8;
        stop_bits = 1'b0; parity_en = 1'b0; parity_odd = 1'b0; rx_read = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_framing", framing_error, 1'b0);
        check("rst_parity", parity_error, 1'b0);
        check("rst_overrun", overrun_error, 1'b0);
        check("rst_rts_n", rts_n, 1'b0);
        reset = 1'b0;
        hold(1'b1, 20);

        // 8N1, divisor 1, 0xA5
        d0 = done_cnt;
        send_frame(8'hA5, 8, 16, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, 4);
        check("a5_done_once", done_cnt, d0 + 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", rx_valid, 1'b1);
        check("a5_framing", framing_error, 1'b0);
        check("a5_parity", parity_error, 1'b0);
        check("a5_overrun", overrun_error, 1'b0);
        check("a5_rts_n_high", rts_n, 1'b1);
        check("a5_done_low", rx_done, 1'b0);
        read_pulse();
        check("a5_read_valid", rx_valid, 1'b0);
        @(negedge clk);
        check("a5_read_rts_n", rts_n, 1'b0);

        // 6N2, divisor 2: upper bits of 0xED are not sent, so 0x2D is expected
        baud_div = 16'd2; data_bits = DATA_BITS_6; stop_bits = 1'b1;
        d0 = done_cnt;
        send_frame(8'hED, 6, 32, 1'b0, 1'b0, 2, 1'b1);
        hold(1'b1, 8);
        check("6n2_done_once", done_cnt, d0 + 1);
        check("6n2_data", rx_data, 8'h2D);
        check("6n2_framing", framing_error, 1'b0);
        read_pulse();

`ifdef UART_RX_PARITY_EN
        // 5E2, divisor 3: 0x13 has three ones -> even parity bit 1
        baud_div = 16'd3; data_bits = DATA_BITS_5; stop_bits = 1'b1;
        parity_en = 1'b1; parity_odd = 1'b0;
        d0 = done_cnt;
        send_frame(8'h13, 5, 48, 1'b1, 1'b1, 2, 1'b1);
        hold(1'b1, 8);
        check("5e2_done_once", done_cnt, d0 + 1);
        check("5e2_data", rx_data, 8'h13);
        check("5e2_parity_ok", parity_error, 1'b0);
        read_pulse();
        send_frame(8'h13, 5, 48, 1'b1, 1'b0, 2, 1'b1);
        hold(1'b1, 8);
        check("5e2_bad_data", rx_data, 8'h13);
        check("5e2_parity_bad", parity_error, 1'b1);
        read_pulse();
        parity_en = 1'b0;
`endif

        // Glitch shorter than half a bit must not start a frame
        baud_div = 16'd1; data_bits = DATA_BITS_8; stop_bits = 1'b0;
        d0 = done_cnt;
        saw_data = 1'b0;
        hold(1'b0, 4);
        hold(1'b1, 48);
        check("glitch_no_done", done_cnt, d0);
        check("glitch_no_data_state", saw_data, 1'b0);
        check("glitch_idle", dut.state_q, IDLE);
        send_frame(8'h81, 8, 16, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, 4);
        check("after_glitch_data", rx_data, 8'h81);
        read_pulse();

        // Back-to-back 0x11, 0x22 without reading
        d0 = done_cnt;
        send_frame(8'h11, 8, 16, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'h22, 8, 16, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, 4);
        check("ovr_done_twice", done_cnt, d0 + 2);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_flag", overrun_error, 1'b1);
        read_pulse();
        check("ovr_read_valid", rx_valid, 1'b0);
        check("ovr_read_clear", overrun_error, 1'b0);
        @(negedge clk);
        check("ovr_read_rts_n", rts_n, 1'b0);

        // Stop bit driven low: byte still delivered, framing error raised
        d0 = done_cnt;
        send_frame(8'h3C, 8, 16, 1'b0, 1'b0, 1, 1'b0);
        hold(1'b1, 32);
        check("fe_done_once", done_cnt, d0 + 1);
        check("fe_data", rx_data, 8'h3C);
        check("fe_flag", framing_error, 1'b1);

        // Reset in the middle of the data bits of 0xFF (holding register still full)
        d0 = done_cnt;
        hold(1'b0, 16);
        hold(1'b1, 40);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_valid", rx_valid, 1'b0);
        check("midrst_framing", framing_error, 1'b0);
        check("midrst_overrun", overrun_error, 1'b0);
        check("midrst_rts_n", rts_n, 1'b0);
        reset = 1'b0;
        hold(1'b1, 128);
        check("midrst_no_done", done_cnt, d0);
        check("midrst_still_empty", rx_valid, 1'b0);

        // Divisor 0 behaves as 1: 0x5A at 16 clocks per bit
        baud_div = 16'd0;
        d0 = done_cnt;
        send_frame(8'h5A, 8, 16, 1'b0, 1'b0, 1, 1'b1);
        hold(1'b1, 4);
        check("5a_done_once", done_cnt, d0 + 1);
        check("5a_data", rx_data, 8'h5A);
        check("5a_framing", framing_error, 1'b0);
        check("5a_valid", rx_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
